// File: rtl/serial_parity_checker.sv
// serial_parity_checker
//   Receives a frame of FRAME_LEN serial data bits followed by one parity bit,
//   computes the XOR of the data bits and flags a mismatch with the received
//   parity bit. The result is presented for one cycle on out_valid.
//
// Parameters
//   FRAME_LEN   : number of data bits per frame (1..255)
//
// Ports
//   clk         : single clock, all state updates on the rising edge
//   rst_n       : synchronous active-low reset
//   in_start    : one-cycle pulse opening a frame (only honoured when idle)
//   in_bit      : serial data or parity bit
//   in_valid    : qualifies in_bit in the current cycle
//   in_ready    : high while a valid bit will be consumed (DATA and PARITY)
//   out_parity  : XOR of the data bits of the last completed frame
//   out_err     : received parity bit differed from out_parity
//   out_valid   : one-cycle strobe qualifying out_parity / out_err
//   out_err_cnt : saturating count of bad-parity frames
//
// Build option
//   PARITY_ERR_CNT_EN : when defined, adds out_err_cnt and its counter.
//                       When undefined, the port and counter are absent.

module serial_parity_checker #(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_start,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_parity,
  output logic       out_err,
  output logic       out_valid
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [7:0] out_err_cnt
`endif
);

  // Counter wide enough to hold FRAME_LEN itself.
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  // Running even-parity update for one accepted bit.
  function automatic logic parity_step(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

  logic [1:0]       state_r,      state_nxt_s;
  logic             acc_r,        acc_nxt_s;
  logic [CNT_W-1:0] cnt_r,        cnt_nxt_s;
  logic             out_parity_r, par_nxt_s;
  logic             out_err_r,    err_nxt_s;
  logic             out_valid_r,  valid_nxt_s;
  logic             in_ready_r,   ready_nxt_s;

  // Next-state and datapath decode for the frame FSM.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    par_nxt_s   = out_parity_r;
    err_nxt_s   = out_err_r;
    valid_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_start) begin
          state_nxt_s = ST_DATA;
          acc_nxt_s   = 1'b0;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (in_valid) begin
          acc_nxt_s = parity_step(acc_r, in_bit);
          cnt_nxt_s = cnt_r + CNT_ONE;
          // Leave DATA on the same cycle the last data bit is accepted.
          if (cnt_r == LAST_IDX) begin
            state_nxt_s = ST_PARITY;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (in_valid) begin
          par_nxt_s   = acc_r;
          err_nxt_s   = parity_step(acc_r, in_bit);
          valid_nxt_s = 1'b1;
          state_nxt_s = ST_RESULT;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
      ST_RESULT: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    // in_ready is registered from the next state so it is glitch-free.
    if ((state_nxt_s == ST_DATA) || (state_nxt_s == ST_PARITY)) begin
      ready_nxt_s = 1'b1;
    end else begin
      ready_nxt_s = 1'b0;
    end
  end

  // State, accumulator, counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      acc_r        <= 1'b0;
      cnt_r        <= '0;
      out_parity_r <= 1'b0;
      out_err_r    <= 1'b0;
      out_valid_r  <= 1'b0;
      in_ready_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      acc_r        <= acc_nxt_s;
      cnt_r        <= cnt_nxt_s;
      out_parity_r <= par_nxt_s;
      out_err_r    <= err_nxt_s;
      out_valid_r  <= valid_nxt_s;
      in_ready_r   <= ready_nxt_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_parity = out_parity_r;
  assign out_err    = out_err_r;
  assign out_valid  = out_valid_r;

`ifdef PARITY_ERR_CNT_EN
  // Add one unless already at the ceiling.
  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    if (val == 8'hFF) begin
      return val;
    end else begin
      return val + 8'd1;
    end
  endfunction

  logic [7:0] err_cnt_r;

  // Count bad frames; the update lands at the end of the RESULT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_r <= 8'd0;
    end else if ((state_r == ST_RESULT) && out_err_r) begin
      err_cnt_r <= sat_inc(err_cnt_r);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign out_err_cnt = err_cnt_r;
`endif

endmodule
